// File: rtl/vx_reduce_arb_if.sv
// Requester-side and reduce-unit-side signals of the reduce arbiter.
// The arbiter takes the slave modport; the issue/reduce environment drives the master modport.
interface vx_reduce_arb_if #(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 64,
  parameter int PID_WIDTH = 1,
  parameter int REQ_BITS  = 2
);
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS-1:0]           req_sop;
  logic [NUM_REQS-1:0]           req_eop;
  logic [NUM_REQS*PID_WIDTH-1:0] req_pid;
  logic [NUM_REQS*DATAW-1:0]     req_data;
  logic [NUM_REQS-1:0]           req_ready;
  logic                          out_valid;
  logic                          out_sop;
  logic                          out_eop;
  logic [PID_WIDTH-1:0]          out_pid;
  logic [DATAW-1:0]              out_data;
  logic [REQ_BITS-1:0]           out_sel;
  logic                          out_ready;
  logic                          busy;
  logic                          err;

  modport master (
    output req_valid, req_sop, req_eop, req_pid, req_data, out_ready,
    input  req_ready, out_valid, out_sop, out_eop, out_pid, out_data, out_sel, busy, err
  );

  modport slave (
    input  req_valid, req_sop, req_eop, req_pid, req_data, out_ready,
    output req_ready, out_valid, out_sop, out_eop, out_pid, out_data, out_sel, busy, err
  );
endinterface

// File: rtl/vx_reduce_arb.sv
// Packet-locked round-robin arbiter sharing one reduce execute port; zero-latency mux.
// A granted sop locks the requester until its eop is accepted; out_ready low holds the lock.
module vx_reduce_arb #(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 64,
  parameter int NUM_PACKETS = 2,
  parameter int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
  parameter int REQ_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic            clk,
  input logic            reset,
  vx_reduce_arb_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [PID_WIDTH:0] LAST_CNT = (PID_WIDTH+1)'(NUM_PACKETS - 1);

  state_e                state_q;
  logic [REQ_BITS-1:0]   rr_ptr_q;
  logic [REQ_BITS-1:0]   lock_id_q;
  logic [PID_WIDTH:0]    pkt_cnt_q;
  logic                  err_q;

  logic [REQ_BITS-1:0]   grant;
  logic [REQ_BITS-1:0]   rr_next;
  logic [REQ_BITS-1:0]   idx;
  logic                  eligible;
  logic                  fire;
  logic                  viol;
  logic [NUM_REQS-1:0]   ready_vec;

  // Scanning downward lets the lowest offset from rr_ptr+1 win without a break.
  always_comb begin
    rr_next  = (int'(rr_ptr_q) >= NUM_REQS - 1) ? '0 : rr_ptr_q + 1'b1;
    grant    = rr_next;
    eligible = 1'b0;
    idx      = '0;
    if (state_q == LOCKED) begin
      grant    = lock_id_q;
      eligible = bus.req_valid[lock_id_q];
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        idx = REQ_BITS'((int'(rr_ptr_q) + 1 + k) % NUM_REQS);
        if (bus.req_valid[idx] && bus.req_sop[idx]) begin
          grant    = idx;
          eligible = 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = eligible && !reset;
  assign bus.out_sel   = reset ? '0 : grant;
  assign bus.out_sop   = bus.req_sop[grant];
  assign bus.out_eop   = bus.req_eop[grant];
  assign bus.out_pid   = bus.req_pid[int'(grant)*PID_WIDTH +: PID_WIDTH];
  assign bus.out_data  = bus.req_data[int'(grant)*DATAW +: DATAW];
  assign bus.busy      = (state_q == LOCKED) && !reset;
  assign bus.err       = err_q;

  assign fire = bus.out_valid && bus.out_ready;

  always_comb begin
    ready_vec = '0;
    if (fire) ready_vec[grant] = 1'b1;
  end
  assign bus.req_ready = ready_vec;

  // Violations: sop disagreeing with state, out-of-order pid, or a packet past the last without eop.
  assign viol = ((state_q == LOCKED) ? bus.out_sop : !bus.out_sop)
             || ({1'b0, bus.out_pid} != pkt_cnt_q)
             || ((state_q == LOCKED) && (pkt_cnt_q == LAST_CNT) && !bus.out_eop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= REQ_BITS'(NUM_REQS - 1);
      lock_id_q <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (fire) begin
      if (viol) err_q <= 1'b1;
      if (state_q == IDLE) begin
        if (bus.out_eop) begin
          rr_ptr_q <= grant;
        end else begin
          state_q   <= LOCKED;
          lock_id_q <= grant;
          pkt_cnt_q <= (PID_WIDTH+1)'(1);
        end
      end else if (bus.out_eop) begin
        state_q   <= IDLE;
        rr_ptr_q  <= lock_id_q;
        pkt_cnt_q <= '0;
      end else begin
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vx_reduce_arb.sv
// Bench for vx_reduce_arb: directed scenarios plus randomized traffic against a reduction-level model.
module tb_vx_reduce_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int NP = 2;
  localparam int PW = 1;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  vx_reduce_arb_if #(.NUM_REQS(N), .DATAW(DW), .PID_WIDTH(PW), .REQ_BITS(RB)) bus ();

  vx_reduce_arb #(.NUM_REQS(N), .DATAW(DW), .NUM_PACKETS(NP), .PID_WIDTH(PW), .REQ_BITS(RB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the unit, where round-robin resumes, packets seen so far.
  bit          m_locked;
  int          m_owner, m_rr, m_cnt;
  bit          m_err;
  bit          exp_valid;
  int          exp_sel;
  logic [N-1:0] exp_ready, m_fire_mask;

  function automatic void model_comb();
    exp_valid = 1'b0;
    exp_sel   = (m_rr + 1) % N;
    exp_ready = '0;
    if (m_locked) begin
      exp_sel   = m_owner;
      exp_valid = bus.req_valid[m_owner];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!exp_valid && bus.req_valid[i] && bus.req_sop[i]) begin
          exp_valid = 1'b1;
          exp_sel   = i;
        end
      end
    end
    if (reset) begin
      exp_valid = 1'b0;
      exp_sel   = 0;
    end
    if (exp_valid && bus.out_ready) exp_ready[exp_sel] = 1'b1;
  endfunction

  function automatic void model_step();
    bit s, e;
    int p;
    model_comb();
    m_fire_mask = exp_ready;
    if (reset) begin
      m_locked = 0; m_owner = 0; m_rr = N - 1; m_cnt = 0; m_err = 0;
    end else if (exp_ready != 0) begin
      s = bus.req_sop[exp_sel];
      e = bus.req_eop[exp_sel];
      p = int'(bus.req_pid[exp_sel*PW +: PW]);
      if (m_locked == s) m_err = 1;
      if (p != m_cnt) m_err = 1;
      if (m_locked && m_cnt == NP - 1 && !e) m_err = 1;
      if (!m_locked) begin
        if (e) m_rr = exp_sel;
        else begin m_locked = 1; m_owner = exp_sel; m_cnt = 1; end
      end else if (e) begin
        m_locked = 0; m_rr = m_owner; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  always @(posedge clk) model_step();

  task automatic set_req(input int i, input bit v, input bit s, input bit e, input int p,
                         input logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_sop[i]             = s;
    bus.req_eop[i]             = e;
    bus.req_pid[i*PW +: PW]    = PW'(p);
    bus.req_data[i*DW +: DW]   = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0; bus.req_sop = '0; bus.req_eop = '0;
    bus.req_pid   = '0; bus.req_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    set_req(1, 1, 1, 1, 0, 64'h11);
    bus.out_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 0000", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.out_sel !== 2'd0) begin n_errors++; $display("FAIL rst_out_sel: got %0d exp 0", bus.out_sel); end
    next_cycle();
    reset = 1'b0;
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL post_rst_err: got %b exp 0", bus.err); end
    n_checks++; if (bus.out_sel !== 2'd0) begin n_errors++; $display("FAIL post_rst_idle_sel: got %0d exp 0", bus.out_sel); end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(0, 1, 1, 0, 0, 64'hA0A0_0000_0000_0001);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid0: got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_sel !== 2'd0) begin n_errors++; $display("FAIL single_sel0: got %0d exp 0", bus.out_sel); end
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready0: got %b exp 0001", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_busy0: got %b exp 0", bus.busy); end
    next_cycle();
    set_req(0, 1, 0, 1, 1, 64'hB0B0_0000_0000_0002);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_busy1: got %b exp 1", bus.busy); end
    n_checks++; if (bus.out_sel !== 2'd0) begin n_errors++; $display("FAIL single_sel1: got %0d exp 0", bus.out_sel); end
    n_checks++; if (bus.out_data !== 64'hB0B0_0000_0000_0002) begin n_errors++; $display("FAIL single_data1: got %h exp b0b0000000000002", bus.out_data); end
    n_checks++; if (bus.out_pid !== 1'b1) begin n_errors++; $display("FAIL single_pid1: got %0d exp 1", bus.out_pid); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end: got %b exp 0", bus.busy); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL single_err: got %b exp 0", bus.err); end
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [N-1:0] er;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 1, 0, 64'(i + 100));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      er = 4'b0001 << (k % N);
      n_checks++; if (bus.out_sel !== RB'(k % N)) begin n_errors++; $display("FAIL fair_sel[%0d]: got %0d exp %0d", k, bus.out_sel, k % N); end
      n_checks++; if (bus.req_ready !== er) begin n_errors++; $display("FAIL fair_ready[%0d]: got %b exp %b", k, bus.req_ready, er); end
      next_cycle();
    end
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL fair_err: got %b exp 0", bus.err); end
    next_cycle();
  endtask

  task automatic test_lock_excl();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(1, 1, 1, 0, 0, 64'h1000);
    set_req(2, 1, 1, 1, 0, 64'h2000);
    @(negedge clk);
    n_checks++; if (bus.out_sel !== 2'd1) begin n_errors++; $display("FAIL lock_first_sel: got %0d exp 1", bus.out_sel); end
    next_cycle();
    set_req(1, 0, 0, 0, 0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL lock_gap_ready[%0d]: got %b exp 0000", k, bus.req_ready); end
      n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL lock_gap_busy[%0d]: got %b exp 1", k, bus.busy); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL lock_gap_valid[%0d]: got %b exp 0", k, bus.out_valid); end
      next_cycle();
    end
    set_req(1, 1, 0, 1, 1, 64'h1001);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_errors++; $display("FAIL lock_eop_ready: got %b exp 0010", bus.req_ready); end
    next_cycle();
    set_req(1, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    n_checks++; if (bus.out_sel !== 2'd2) begin n_errors++; $display("FAIL lock_next_sel: got %0d exp 2", bus.out_sel); end
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL lock_next_ready: got %b exp 0100", bus.req_ready); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(3, 1, 1, 0, 0, 64'h3333_0000);
    @(negedge clk);
    n_checks++; if (bus.out_sel !== 2'd3) begin n_errors++; $display("FAIL bp_first_sel: got %0d exp 3", bus.out_sel); end
    next_cycle();
    set_req(3, 1, 0, 1, 1, 64'h3333_0001);
    set_req(0, 1, 1, 1, 0, 64'h0000_5555);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (bus.out_data !== 64'h3333_0001) begin n_errors++; $display("FAIL bp_data[%0d]: got %h exp 0000000033330001", k, bus.out_data); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b exp 0000", k, bus.req_ready); end
      n_checks++; if (bus.out_sel !== 2'd3 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL bp_hold[%0d]: got sel %0d busy %b exp sel 3 busy 1", k, bus.out_sel, bus.busy); end
      next_cycle();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_errors++; $display("FAIL bp_release_ready: got %b exp 1000", bus.req_ready); end
    next_cycle();
    set_req(3, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0001 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL bp_after: got ready %b busy %b exp ready 0001 busy 0", bus.req_ready, bus.busy); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_proto_err();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(0, 1, 0, 0, 0, 64'h77);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL nosop_valid: got %b exp 0", bus.out_valid); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL nosop_err: got %b exp 0", bus.err); end
    set_req(0, 1, 1, 0, 0, 64'h78);
    next_cycle();
    set_req(0, 1, 0, 0, 0, 64'h79);
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL badpid_pre: got %b exp 0", bus.err); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL badpid_err: got %b exp 1", bus.err); end
    repeat (3) next_cycle();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL badpid_sticky: got %b exp 1", bus.err); end
    next_cycle();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(0, 1, 1, 0, 0, 64'h80);
    next_cycle();
    set_req(0, 1, 0, 0, 1, 64'h81);
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL overrun_pre: got %b exp 0", bus.err); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL overrun_err: got %b exp 1", bus.err); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(2, 1, 1, 0, 0, 64'h2222);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL midrst_locked: got %b exp 1", bus.busy); end
    next_cycle();
    reset = 1'b1;
    set_req(0, 1, 1, 1, 0, 64'h0001);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b exp 0", bus.out_valid); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin n_errors++; $display("FAIL midrst_state: got busy %b err %b exp 0 0", bus.busy, bus.err); end
    n_checks++; if (bus.out_sel !== 2'd0 || bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_grant: got sel %0d ready %b exp 0 0001", bus.out_sel, bus.req_ready); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_random();
    bit           g_on[N], g_vld[N];
    int           g_len[N], g_pos[N], g_pid[N];
    logic [DW-1:0] g_data[N];
    do_reset();
    for (int i = 0; i < N; i++) begin g_on[i] = 0; g_vld[i] = 0; g_len[i] = 1; g_pos[i] = 0; g_pid[i] = 0; g_data[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_fire_mask[i]) begin
          g_vld[i] = 0;
          g_pos[i]++;
          if (g_pos[i] == g_len[i]) g_on[i] = 0;
        end
        if (!g_on[i] && $urandom_range(0, 2) == 0) begin
          g_on[i] = 1; g_len[i] = $urandom_range(1, NP); g_pos[i] = 0;
        end
        if (g_on[i] && !g_vld[i] && $urandom_range(0, 1) == 0) begin
          g_vld[i]  = 1;
          g_pid[i]  = g_pos[i] ^ int'($urandom_range(0, 29) == 0);
          g_data[i] = {$urandom, $urandom};
        end
        set_req(i, g_vld[i], g_on[i] && g_pos[i] == 0, g_pos[i] == g_len[i] - 1, g_pid[i], g_data[i]);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_comb();
      n_checks++; if (bus.out_valid !== exp_valid) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", c, bus.out_valid, exp_valid); end
      n_checks++; if (bus.out_sel !== RB'(exp_sel)) begin n_errors++; $display("FAIL rnd_sel[%0d]: got %0d exp %0d", c, bus.out_sel, exp_sel); end
      n_checks++; if (bus.req_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", c, bus.req_ready, exp_ready); end
      n_checks++; if (bus.busy !== m_locked || bus.err !== m_err) begin n_errors++; $display("FAIL rnd_flags[%0d]: got busy %b err %b exp busy %b err %b", c, bus.busy, bus.err, m_locked, m_err); end
      if (exp_valid) begin
        n_checks++; if (bus.out_data !== bus.req_data[exp_sel*DW +: DW]) begin n_errors++; $display("FAIL rnd_data[%0d]: got %h exp %h", c, bus.out_data, g_data[exp_sel]); end
      end
      next_cycle();
    end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_fairness();
    test_lock_excl();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vx_reduce_arb.md
Name: VX_reduce_arb

Overview:
- Packet-locked round-robin arbiter that shares one reduce unit's execute port among NUM_REQS issue requesters.
- A reduction spans several packets (sop..eop, one per lane group). Once a requester's sop packet is granted, the arbiter locks onto that requester until its eop packet is accepted. Packets from different warps are therefore never interleaved into the accumulator.
- Sits between the issue slots and the reduce unit's execute interface. It also checks the packet protocol and flags violations.

Parameters:
- NUM_REQS, 4, number of requesters (≥1)
- DATAW, 64, opaque payload width per packet (uuid/wid/tmask/op/rs1 etc.)
- NUM_PACKETS, 2, packets per full reduction (`NUM_THREADS / NUM_LANES`)
- PID_WIDTH, `UP(`CLOG2(NUM_PACKETS)), packet-id width
- REQ_BITS, `UP(`CLOG2(NUM_REQS)), requester index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  per-requester packet valid
- req_sop  in  NUM_REQS  per-requester start-of-reduction flag
- req_eop  in  NUM_REQS  per-requester end-of-reduction flag
- req_pid  in  NUM_REQS*PID_WIDTH  per-requester packet id
- req_data  in  NUM_REQS*DATAW  per-requester payload
- req_ready  out  NUM_REQS  per-requester accept
- out_valid  out  1  packet to reduce unit valid
- out_sop, out_eop  out  1 each  forwarded flags
- out_pid  out  PID_WIDTH  forwarded pid
- out_data  out  DATAW  forwarded payload
- out_sel  out  REQ_BITS  index of the granted requester
- out_ready  in  1  reduce unit accept
- busy  out  1  high while LOCKED
- err  out  1  sticky protocol-violation flag

Behaviour:
- Datapath: zero-latency combinational mux from the granted requester, with no registers on it. out_valid = req_valid[grant] && eligible.
- Fire condition: fire = out_valid && out_ready. req_ready[i] = out_ready && (i == grant) && eligible, and 0 for all other i.
- States: IDLE, LOCKED. Registers: state, rr_ptr (REQ_BITS), lock_id, pkt_cnt (PID_WIDTH+1), err.
- Reset values: state=IDLE, rr_ptr=NUM_REQS-1 (requester 0 has first priority), lock_id=0, pkt_cnt=0, err=0.
- Outputs under reset: out_valid=0, req_ready=0, busy=0, out_sel=0.
- IDLE, eligibility: requester i is eligible iff req_valid[i] && req_sop[i].
- IDLE, grant: the first eligible index searching from rr_ptr+1 upward with wrap. If none is eligible, out_valid=0 and out_sel=rr_ptr+1 mod NUM_REQS.
- IDLE, fire with eop: single-packet reduction. Stay in IDLE; rr_ptr <= grant.
- IDLE, fire without eop: go to LOCKED; lock_id <= grant; pkt_cnt <= 1.
- IDLE, non-sop heads: a requester with valid && !sop is ignored, never granted, and does not set err.
- LOCKED, grant: grant = lock_id; eligible = req_valid[lock_id], regardless of sop.
- LOCKED, other requesters: req_ready=0.
- LOCKED, fire without eop: pkt_cnt++.
- LOCKED, fire with eop: go to IDLE; rr_ptr <= lock_id; pkt_cnt <= 0. The next grant can occur in the cycle after the eop fire.
- Stalls: out_ready low holds the lock indefinitely; there is no timeout. The payload must be held stable by the requester while valid && !ready.
- busy = (state == LOCKED).
- err (sticky until reset; the packet is still forwarded) is set on fire when any of these holds:
  - the sop flag disagrees with the state: sop in LOCKED, or sop missing in IDLE (unreachable by construction);
  - out_pid != pkt_cnt, with pid expected to run 0,1,... within a reduction;
  - in LOCKED, pkt_cnt == NUM_PACKETS-1 and the fired packet is not eop (overrun).
- NUM_REQS==1: the arbiter degenerates to a pass-through with lock and protocol checks; rr_ptr stays 0.
- Reset asserted mid-reduction: the lock is dropped immediately, with no flush of the downstream reduce unit. The system resets both units together.

Test Plan:
- Single requester, 2-packet reduction: req0 sends pid0 sop, then pid1 eop, with out_ready=1. Expect out_sel=0 on both packets; busy=1 for exactly 1 cycle (after pid0); err=0; back to IDLE.
- Fairness: req0..3 all hold single-packet sop+eop reductions continuously, out_ready=1. Grant order must be 0,1,2,3,0,1… one per cycle.
- Lock exclusion: req1 in LOCKED after pid0, req2 valid with sop, req1 deasserts valid for 3 cycles, then sends pid1 eop. Expect req2 ready=0 throughout; req2 granted the cycle after req1's eop fire.
- Backpressure: out_ready=0 for 5 cycles during req3's pid1. Expect out_data stable, req_ready[3]=0, no state change; fire when out_ready returns to 1.
- Protocol errors: send pid0 sop, then pid0 (wrong pid) → err=1 and stays 1. After reset, send pid0 sop, pid1 without eop at NUM_PACKETS=2 → err=1.
- Reset mid-lock: assert reset while LOCKED on req2. Next cycle expect busy=0, err=0, and req0 granted first if valid with sop.
